// File: rtl/instr_fetcher_if.sv
// Fetch-unit handshake bundle: icache request/response, decoder queue head, RoB redirect.
interface instr_fetcher_if;
  logic        IF2IC_en;
  logic [31:0] IF2IC_addr;
  logic        IC2IF_en;
  logic [31:0] IC2IF_instr;
  logic        IF2DC_en;
  logic [31:0] IF2DC_instr;
  logic [31:0] IF2DC_pc;
  logic        IF2DC_pred_taken;
  logic        DC2IF_ready;
  logic        RoB2IF_flush;
  logic [31:0] RoB2IF_target_pc;

  modport master (
    output IF2IC_en, IF2IC_addr, IF2DC_en, IF2DC_instr, IF2DC_pc, IF2DC_pred_taken,
    input  IC2IF_en, IC2IF_instr, DC2IF_ready, RoB2IF_flush, RoB2IF_target_pc
  );

  modport slave (
    input  IF2IC_en, IF2IC_addr, IF2DC_en, IF2DC_instr, IF2DC_pc, IF2DC_pred_taken,
    output IC2IF_en, IC2IF_instr, DC2IF_ready, RoB2IF_flush, RoB2IF_target_pc
  );
endinterface

// File: rtl/instr_fetcher.sv
// Instruction fetcher: one outstanding icache request, static branch prediction, circular queue to decode.
// Request registered one cycle after FETCH; queue head is combinational; full queue or rdy_in=0 stalls fetch.
module instr_fetcher #(
  parameter int          IQ_WIDTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  instr_fetcher_if.master bus
);
  localparam int IQ_DEPTH = 1 << IQ_WIDTH;

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  state_t              state;
  logic [31:0]         pc;
  logic                req_en;
  logic [31:0]         req_addr;
  iq_entry_t           queue [IQ_DEPTH];
  logic [IQ_WIDTH-1:0] head;
  logic [IQ_WIDTH-1:0] tail;
  logic [IQ_WIDTH:0]   count;

  logic [31:0] instr;
  logic [31:0] jal_imm;
  logic [31:0] br_imm;
  logic [31:0] next_pc;
  logic        pred;
  logic        iq_full;
  logic        push;
  logic        pop;

  always_comb begin
    instr   = bus.IC2IF_instr;
    jal_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    br_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    next_pc = pc + 32'd4;
    pred    = 1'b0;
    if (instr[6:0] == 7'b1101111) begin
      next_pc = pc + jal_imm;
      pred    = 1'b1;
    end else if (instr[6:0] == 7'b1100011 && instr[31]) begin
      // Backward branches are predicted taken (loops); forward ones fall through.
      next_pc = pc + br_imm;
      pred    = 1'b1;
    end
  end

  // Count never exceeds IQ_DEPTH, so its top bit alone marks a full queue.
  assign iq_full = count[IQ_WIDTH];
  assign push    = (state == WAIT) && bus.IC2IF_en;
  assign pop     = (count != '0) && bus.DC2IF_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_en   <= 1'b0;
      req_addr <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) queue[i] <= '0;
    end else if (!rdy_in) begin
      req_en <= 1'b0;
    end else if (bus.RoB2IF_flush) begin
      req_en <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      pc     <= bus.RoB2IF_target_pc;
      // A request still in flight must have its response swallowed before fetching again.
      state  <= (state != FETCH && !bus.IC2IF_en) ? DISCARD : FETCH;
    end else begin
      req_en <= 1'b0;
      if (push) begin
        queue[tail] <= {bus.IC2IF_instr, pc, pred};
        tail        <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      case (state)
        FETCH: if (!iq_full) begin
          req_en   <= 1'b1;
          req_addr <= pc;
          state    <= WAIT;
        end
        WAIT: if (bus.IC2IF_en) begin
          pc    <= next_pc;
          state <= FETCH;
        end
        DISCARD: if (bus.IC2IF_en) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.IF2IC_en         = req_en;
  assign bus.IF2IC_addr       = req_addr;
  assign bus.IF2DC_en         = (count != '0);
  assign bus.IF2DC_instr      = queue[head].instr;
  assign bus.IF2DC_pc         = queue[head].pc;
  assign bus.IF2DC_pred_taken = queue[head].pred;
endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: reset, prediction, queue full, flush variants, rdy_in freeze.
module tb_instr_fetcher;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   total = 0;
  int   bad   = 0;

  instr_fetcher_if bus();

  instr_fetcher #(.IQ_WIDTH(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input int budget, output logic [31:0] addr, output bit seen);
    seen = 1'b0;
    addr = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.IF2IC_en === 1'b1) begin
        seen = 1'b1;
        addr = bus.IF2IC_addr;
      end
    end
  endtask

  task automatic respond(input logic [31:0] w);
    bus.IC2IF_en    = 1'b1;
    bus.IC2IF_instr = w;
    step();
    bus.IC2IF_en    = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    bit          s;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    bus.IC2IF_en = 1'b0;
    bus.IC2IF_instr = '0;
    bus.DC2IF_ready = 1'b0;
    bus.RoB2IF_flush = 1'b0;
    bus.RoB2IF_target_pc = '0;
    repeat (3) step();
    total++;
    if (bus.IF2IC_en !== 1'b0 || bus.IF2IC_addr !== 32'h0) begin
      bad++; $display("FAIL reset_ic: en=%b addr=%h want 0/00000000", bus.IF2IC_en, bus.IF2IC_addr);
    end
    total++;
    if (bus.IF2DC_en !== 1'b0 || bus.IF2DC_instr !== 32'h0 || bus.IF2DC_pc !== 32'h0 || bus.IF2DC_pred_taken !== 1'b0) begin
      bad++; $display("FAIL reset_dc: en=%b instr=%h pc=%h pred=%b want all 0", bus.IF2DC_en, bus.IF2DC_instr, bus.IF2DC_pc, bus.IF2DC_pred_taken);
    end
    rst_in = 1'b1;
    wait_req(4, a, s);
    total++;
    if (!s || a !== 32'h0) begin
      bad++; $display("FAIL first_req: seen=%b addr=%h want 1/00000000", s, a);
    end
    total++;
    if (bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL first_req_dc: IF2DC_en=%b want 0", bus.IF2DC_en);
    end
    step();
    total++;
    if (bus.IF2IC_en !== 1'b0 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL pulse_width: IF2IC_en=%b IF2DC_en=%b want 0/0", bus.IF2IC_en, bus.IF2DC_en);
    end
  endtask

  task automatic test_next_pc();
    logic [31:0] a;
    bit          s;
    logic [31:0] t_pc  [9];
    logic [31:0] t_ins [9];
    logic        t_prd [9];
    logic [31:0] t_nxt [9];
    t_pc  = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h1C, 32'h20};
    t_ins = '{32'h13, 32'h13, 32'h13, 32'h0080006F, 32'h13, 32'h13, 32'hFE000EE3, 32'h00000463, 32'h000080E7};
    t_prd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_nxt = '{32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h1C, 32'h20, 32'h24};
    respond(32'h13);
    total++;
    if (bus.IF2DC_en !== 1'b1 || bus.IF2DC_instr !== 32'h13 || bus.IF2DC_pc !== 32'h0 || bus.IF2DC_pred_taken !== 1'b0) begin
      bad++; $display("FAIL nop_head: en=%b instr=%h pc=%h pred=%b want 1/00000013/00000000/0", bus.IF2DC_en, bus.IF2DC_instr, bus.IF2DC_pc, bus.IF2DC_pred_taken);
    end
    bus.DC2IF_ready = 1'b1;
    wait_req(4, a, s);
    total++;
    if (!s || a !== 32'h4) begin
      bad++; $display("FAIL nop_next: seen=%b addr=%h want 1/00000004", s, a);
    end
    for (int k = 0; k < 9; k++) begin
      respond(t_ins[k]);
      total++;
      if (bus.IF2DC_en !== 1'b1 || bus.IF2DC_instr !== t_ins[k] || bus.IF2DC_pc !== t_pc[k] || bus.IF2DC_pred_taken !== t_prd[k]) begin
        bad++; $display("FAIL head_%0d: en=%b instr=%h pc=%h pred=%b want 1/%h/%h/%b", k, bus.IF2DC_en, bus.IF2DC_instr, bus.IF2DC_pc, bus.IF2DC_pred_taken, t_ins[k], t_pc[k], t_prd[k]);
      end
      wait_req(4, a, s);
      total++;
      if (!s || a !== t_nxt[k]) begin
        bad++; $display("FAIL next_%0d: seen=%b addr=%h want 1/%h", k, s, a, t_nxt[k]);
      end
    end
  endtask

  task automatic test_queue_full();
    logic [31:0] a;
    bit          s;
    int          nreq;
    bus.DC2IF_ready = 1'b0;
    total++;
    if (bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL full_start: IF2DC_en=%b want 0", bus.IF2DC_en);
    end
    for (int k = 0; k < 4; k++) begin
      respond(32'h13);
      if (k < 3) begin
        wait_req(4, a, s);
        total++;
        if (!s || a !== 32'h28 + 32'(4 * k)) begin
          bad++; $display("FAIL fill_%0d: seen=%b addr=%h want 1/%h", k, s, a, 32'h28 + 32'(4 * k));
        end
      end
    end
    total++;
    if (bus.IF2DC_en !== 1'b1 || bus.IF2DC_pc !== 32'h24) begin
      bad++; $display("FAIL full_head: en=%b pc=%h want 1/00000024", bus.IF2DC_en, bus.IF2DC_pc);
    end
    nreq = 0;
    repeat (6) begin
      step();
      if (bus.IF2IC_en === 1'b1) nreq++;
    end
    total++;
    if (nreq != 0) begin
      bad++; $display("FAIL full_stall: requests=%0d want 0", nreq);
    end
    bus.DC2IF_ready = 1'b1;
    step();
    bus.DC2IF_ready = 1'b0;
    total++;
    if (bus.IF2DC_pc !== 32'h28) begin
      bad++; $display("FAIL pop_head: pc=%h want 00000028", bus.IF2DC_pc);
    end
    nreq = 0;
    a = '0;
    repeat (6) begin
      step();
      if (bus.IF2IC_en === 1'b1) begin
        nreq++;
        a = bus.IF2IC_addr;
      end
    end
    total++;
    if (nreq != 1 || a !== 32'h34) begin
      bad++; $display("FAIL pop_refill: requests=%0d addr=%h want 1/00000034", nreq, a);
    end
  endtask

  task automatic test_flush_wait();
    logic [31:0] a;
    bit          s;
    int          nreq;
    nreq = 0;
    bus.RoB2IF_flush = 1'b1;
    bus.RoB2IF_target_pc = 32'h80;
    step();
    if (bus.IF2IC_en === 1'b1) nreq++;
    total++;
    if (bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL flush_empty: IF2DC_en=%b want 0", bus.IF2DC_en);
    end
    bus.RoB2IF_target_pc = 32'h100;
    step();
    if (bus.IF2IC_en === 1'b1) nreq++;
    bus.RoB2IF_flush = 1'b0;
    respond(32'h0080006F);
    if (bus.IF2IC_en === 1'b1) nreq++;
    total++;
    if (nreq != 0 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL discard: requests=%0d IF2DC_en=%b want 0/0", nreq, bus.IF2DC_en);
    end
    wait_req(4, a, s);
    total++;
    if (!s || a !== 32'h100 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL flush_redirect: seen=%b addr=%h dc_en=%b want 1/00000100/0", s, a, bus.IF2DC_en);
    end
  endtask

  task automatic test_flush_same_cycle();
    logic [31:0] a;
    bit          s;
    respond(32'h13);
    wait_req(4, a, s);
    total++;
    if (!s || a !== 32'h104 || bus.IF2DC_en !== 1'b1 || bus.IF2DC_pc !== 32'h100) begin
      bad++; $display("FAIL pre_flush: seen=%b addr=%h dc_en=%b dc_pc=%h want 1/00000104/1/00000100", s, a, bus.IF2DC_en, bus.IF2DC_pc);
    end
    bus.RoB2IF_flush = 1'b1;
    bus.RoB2IF_target_pc = 32'h200;
    bus.DC2IF_ready = 1'b1;
    respond(32'h13);
    bus.RoB2IF_flush = 1'b0;
    bus.DC2IF_ready = 1'b0;
    total++;
    if (bus.IF2DC_en !== 1'b0 || bus.IF2IC_en !== 1'b0) begin
      bad++; $display("FAIL same_flush: dc_en=%b ic_en=%b want 0/0", bus.IF2DC_en, bus.IF2IC_en);
    end
    wait_req(4, a, s);
    total++;
    if (!s || a !== 32'h200 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL same_redirect: seen=%b addr=%h dc_en=%b want 1/00000200/0", s, a, bus.IF2DC_en);
    end
  endtask

  task automatic test_flush_fetch();
    logic [31:0] a;
    bit          s;
    respond(32'h13);
    total++;
    if (bus.IF2DC_en !== 1'b1) begin
      bad++; $display("FAIL fetch_push: IF2DC_en=%b want 1", bus.IF2DC_en);
    end
    bus.RoB2IF_flush = 1'b1;
    bus.RoB2IF_target_pc = 32'h300;
    step();
    bus.RoB2IF_flush = 1'b0;
    total++;
    if (bus.IF2IC_en !== 1'b0 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL fetch_flush: ic_en=%b dc_en=%b want 0/0", bus.IF2IC_en, bus.IF2DC_en);
    end
    wait_req(4, a, s);
    total++;
    if (!s || a !== 32'h300) begin
      bad++; $display("FAIL fetch_redirect: seen=%b addr=%h want 1/00000300", s, a);
    end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] a;
    bit          s;
    int          nreq;
    respond(32'h13);
    rdy_in = 1'b0;
    bus.DC2IF_ready = 1'b1;
    nreq = 0;
    repeat (3) begin
      step();
      if (bus.IF2IC_en === 1'b1) nreq++;
    end
    total++;
    if (nreq != 0 || bus.IF2DC_en !== 1'b1 || bus.IF2DC_pc !== 32'h300) begin
      bad++; $display("FAIL freeze: requests=%0d dc_en=%b dc_pc=%h want 0/1/00000300", nreq, bus.IF2DC_en, bus.IF2DC_pc);
    end
    rdy_in = 1'b1;
    wait_req(4, a, s);
    bus.DC2IF_ready = 1'b0;
    total++;
    if (!s || a !== 32'h304 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL unfreeze: seen=%b addr=%h dc_en=%b want 1/00000304/0", s, a, bus.IF2DC_en);
    end
  endtask

  task automatic test_reset_mid_wait();
    rst_in = 1'b0;
    #1;
    total++;
    if (bus.IF2IC_en !== 1'b0 || bus.IF2IC_addr !== 32'h0) begin
      bad++; $display("FAIL async_reset: en=%b addr=%h want 0/00000000", bus.IF2IC_en, bus.IF2IC_addr);
    end
    step();
    rst_in = 1'b1;
    respond(32'h0080006F);
    total++;
    if (bus.IF2IC_en !== 1'b1 || bus.IF2IC_addr !== 32'h0 || bus.IF2DC_en !== 1'b0) begin
      bad++; $display("FAIL post_reset: ic_en=%b addr=%h dc_en=%b want 1/00000000/0", bus.IF2IC_en, bus.IF2IC_addr, bus.IF2DC_en);
    end
    step();
    total++;
    if (bus.IF2DC_en !== 1'b0 || bus.IF2IC_en !== 1'b0) begin
      bad++; $display("FAIL stale_ignored: dc_en=%b ic_en=%b want 0/0", bus.IF2DC_en, bus.IF2IC_en);
    end
  endtask

  initial begin
    test_reset();
    test_next_pc();
    test_queue_full();
    test_flush_wait();
    test_flush_same_cycle();
    test_flush_fetch();
    test_rdy_freeze();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
